// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//   Independent safety monitor on the highway/farm traffic light outputs.
//   Latches the first fault seen (conflict, illegal encoding, illegal colour
//   sequence, short yellow) and drives a flash-mode request plus a blink
//   output that take over the lamp drivers downstream.
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   light_highway  highway lamps, one-hot: 001 green, 010 yellow, 100 red
//   light_farm     farm-road lamps, same encoding
//   fault_clr      level request to clear a latched fault
//   fault          latched fault / flash-mode request
//   fault_code     0 none, 1 conflict, 2 encoding, 3 sequence, 4 short yellow
//   flash_out      blink drive, toggles while fault is set
module traffic_conflict_monitor #(
  parameter int unsigned GLITCH_CYC  = 2,
  parameter int unsigned MIN_YEL_CYC = 8,
  parameter int unsigned FLASH_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] light_highway,
  input  logic [2:0] light_farm,
  input  logic       fault_clr,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_out
);

  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  localparam int unsigned IW = $clog2(GLITCH_CYC + 1);
  localparam int unsigned YW = $clog2(MIN_YEL_CYC + 1);
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  localparam logic [IW-1:0] GLITCH_MAX = IW'(GLITCH_CYC);
  localparam logic [YW-1:0] YEL_MAX    = YW'(MIN_YEL_CYC);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    CODE_NONE      = 3'd0,
    CODE_CONFLICT  = 3'd1,
    CODE_ENCODING  = 3'd2,
    CODE_SEQUENCE  = 3'd3,
    CODE_SHORT_YEL = 3'd4
  } code_e;

  logic [IW-1:0] inv_h, inv_f, inv_h_nxt, inv_f_nxt;
  logic [YW-1:0] yel_h, yel_f, yel_h_nxt, yel_f_nxt;
  logic [FW-1:0] flash_cnt;
  logic [2:0]    prev_h, prev_f;
  logic          primed;
  code_e         code_q, err_code;

  logic valid_h, valid_f, valid;
  logic enc_err, conflict_err, seq_err, short_err, clear;

  // Only G->R, Y->G and R->Y are illegal; unchanged and forward steps pass.
  function automatic logic seq_bad(input logic [2:0] p, input logic [2:0] c);
    return ((p == LG) && (c == LR)) || ((p == LY) && (c == LG)) ||
           ((p == LR) && (c == LY));
  endfunction

  function automatic logic short_yel(input logic [2:0] p, input logic [2:0] c,
                                     input logic [YW-1:0] cnt);
    return (p == LY) && (c == LR) && (cnt < YEL_MAX);
  endfunction

  always_comb begin
    valid_h = $onehot(light_highway);
    valid_f = $onehot(light_farm);
    valid   = valid_h && valid_f;

    inv_h_nxt = '0;
    inv_f_nxt = '0;
    if (!valid_h) inv_h_nxt = (inv_h == GLITCH_MAX) ? inv_h : inv_h + IW'(1);
    if (!valid_f) inv_f_nxt = (inv_f == GLITCH_MAX) ? inv_f : inv_f + IW'(1);
    enc_err = (inv_h_nxt == GLITCH_MAX) || (inv_f_nxt == GLITCH_MAX);

    // Invalid samples hold the yellow timers.
    yel_h_nxt = yel_h;
    yel_f_nxt = yel_f;
    if (valid) begin
      yel_h_nxt = (light_highway != LY) ? '0 :
                  (yel_h == YEL_MAX) ? yel_h : yel_h + YW'(1);
      yel_f_nxt = (light_farm != LY) ? '0 :
                  (yel_f == YEL_MAX) ? yel_f : yel_f + YW'(1);
    end

    conflict_err = valid && (light_highway != LR) && (light_farm != LR);
    seq_err   = valid && primed &&
                (seq_bad(prev_h, light_highway) || seq_bad(prev_f, light_farm));
    short_err = valid && primed &&
                (short_yel(prev_h, light_highway, yel_h) ||
                 short_yel(prev_f, light_farm, yel_f));

    err_code = CODE_NONE;
    if (conflict_err)   err_code = CODE_CONFLICT;
    else if (enc_err)   err_code = CODE_ENCODING;
    else if (seq_err)   err_code = CODE_SEQUENCE;
    else if (short_err) err_code = CODE_SHORT_YEL;

    clear = fault && fault_clr && valid && !conflict_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault     <= 1'b0;
      code_q    <= CODE_NONE;
      flash_out <= 1'b0;
      flash_cnt <= '0;
      inv_h     <= '0;
      inv_f     <= '0;
      yel_h     <= '0;
      yel_f     <= '0;
      prev_h    <= '0;
      prev_f    <= '0;
      primed    <= 1'b0;
    end else begin
      inv_h <= inv_h_nxt;
      inv_f <= inv_f_nxt;
      if (clear) begin
        // prev is left stale: primed=0 makes the next valid sample reload it.
        fault     <= 1'b0;
        code_q    <= CODE_NONE;
        flash_out <= 1'b0;
        flash_cnt <= '0;
        yel_h     <= '0;
        yel_f     <= '0;
        primed    <= 1'b0;
      end else begin
        if (valid) begin
          prev_h <= light_highway;
          prev_f <= light_farm;
          primed <= 1'b1;
        end
        yel_h <= yel_h_nxt;
        yel_f <= yel_f_nxt;
        if (fault) begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt <= '0;
            flash_out <= ~flash_out;
          end else begin
            flash_cnt <= flash_cnt + FW'(1);
          end
        end else if (err_code != CODE_NONE) begin
          fault     <= 1'b1;
          code_q    <= err_code;
          flash_out <= 1'b0;
          flash_cnt <= '0;
        end
      end
    end
  end

  assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
module tb_traffic_conflict_monitor;

  localparam int GLITCH = 2;
  localparam int MINY   = 8;
  localparam int FDIV   = 4;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] light_highway = G;
  logic [2:0] light_farm = R;
  logic       fault_clr = 1'b0;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_out;

  int checks = 0;
  int errors = 0;

  traffic_conflict_monitor #(
    .GLITCH_CYC (GLITCH),
    .MIN_YEL_CYC(MINY),
    .FLASH_DIV  (FDIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .light_highway(light_highway),
    .light_farm   (light_farm),
    .fault_clr    (fault_clr),
    .fault        (fault),
    .fault_code   (fault_code),
    .flash_out    (flash_out)
  );

  always #5 clk = ~clk;

  // Reference model: colours as indices 0=G,1=Y,2=R; the legal successor of
  // colour p is (p+1)%3. Flash phase derives from the age of the fault.
  int m_fault, m_code, m_age, m_primed;
  int m_prev_h, m_prev_f, m_yel_h, m_yel_f, m_inv_h, m_inv_f;

  function automatic int colour(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_fault = 0; m_code = 0; m_age = 0; m_primed = 0;
    m_prev_h = 0; m_prev_f = 0; m_yel_h = 0; m_yel_f = 0;
    m_inv_h = 0; m_inv_f = 0;
  endtask

  task automatic model_step(input logic [2:0] h, input logic [2:0] f, input logic clr);
    int ch, cf;
    bit vh, vf, valid, conf, enc, seq, shrt;
    ch = colour(h);
    cf = colour(f);
    vh = (ch >= 0);
    vf = (cf >= 0);
    valid = vh && vf;
    m_inv_h = vh ? 0 : m_inv_h + 1;
    m_inv_f = vf ? 0 : m_inv_f + 1;
    enc  = (m_inv_h >= GLITCH) || (m_inv_f >= GLITCH);
    conf = valid && (ch != 2) && (cf != 2);
    if (m_fault != 0 && clr && valid && !conf) begin
      m_fault = 0; m_code = 0; m_age = 0; m_primed = 0;
      m_yel_h = 0; m_yel_f = 0;
    end else begin
      seq = 0;
      shrt = 0;
      if (valid) begin
        if (m_primed != 0) begin
          if (ch != m_prev_h && ch != (m_prev_h + 1) % 3) seq = 1;
          if (cf != m_prev_f && cf != (m_prev_f + 1) % 3) seq = 1;
          if (m_prev_h == 1 && ch == 2 && m_yel_h < MINY) shrt = 1;
          if (m_prev_f == 1 && cf == 2 && m_yel_f < MINY) shrt = 1;
        end
        m_yel_h = (ch == 1) ? m_yel_h + 1 : 0;
        m_yel_f = (cf == 1) ? m_yel_f + 1 : 0;
        m_prev_h = ch;
        m_prev_f = cf;
        m_primed = 1;
      end
      if (m_fault != 0) begin
        m_age++;
      end else if (conf || enc || seq || shrt) begin
        m_fault = 1;
        m_age = 0;
        m_code = conf ? 1 : enc ? 2 : seq ? 3 : 4;
      end
    end
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] h, input logic [2:0] f, input logic clr,
                     input string tag);
    logic [2:0] exp_flash;
    light_highway = h;
    light_farm = f;
    fault_clr = clr;
    @(posedge clk);
    model_step(h, f, clr);
    #1;
    exp_flash = (m_fault != 0 && ((m_age / FDIV) % 2) == 1) ? 3'd1 : 3'd0;
    check({tag, ".fault"}, {2'b0, fault}, 3'(m_fault));
    check({tag, ".code"}, fault_code, 3'(m_code));
    check({tag, ".flash"}, {2'b0, flash_out}, exp_flash);
  endtask

  task automatic hold(input logic [2:0] h, input logic [2:0] f, input logic clr,
                      input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(h, f, clr, tag);
  endtask

  // Asserts reset away from a clock edge and checks the outputs drop at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    check({tag, ".fault"}, {2'b0, fault}, 3'd0);
    check({tag, ".code"}, fault_code, 3'd0);
    check({tag, ".flash"}, {2'b0, flash_out}, 3'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic legal_cycle(input string tag);
    hold(G, R, 0, 3, tag);
    hold(Y, R, 0, 12, tag);
    hold(R, G, 0, 3, tag);
    hold(R, Y, 0, 12, tag);
    hold(G, R, 0, 3, tag);
  endtask

  logic [2:0] ph_h [4] = '{G, Y, R, R};
  logic [2:0] ph_f [4] = '{R, R, G, Y};

  initial begin
    int phase, r;
    logic [2:0] cur_h, cur_f;
    logic clr;
    model_reset();
    #1;
    do_reset("reset");

    // 1: full legal cycle
    legal_cycle("legal");

    // 2: conflict, then flash cadence
    cyc(G, G, 0, "conflict");
    hold(G, R, 0, 12, "flash");

    // 3: single invalid sample tolerated, two in a row fault
    do_reset("reset3");
    hold(G, R, 0, 2, "enc.pre");
    cyc(3'b000, R, 0, "enc.one");
    hold(G, R, 0, 2, "enc.back");
    hold(3'b011, R, 0, 2, "enc.two");
    hold(G, R, 0, 2, "enc.after");

    // 4: illegal sequences
    do_reset("reset4a");
    hold(G, R, 0, 2, "seq.pre");
    hold(R, R, 0, 2, "seq.g2r");
    do_reset("reset4b");
    hold(R, R, 0, 2, "seq.pre2");
    hold(R, Y, 0, 2, "seq.r2y");

    // 5: short yellow vs exactly minimum yellow
    do_reset("reset5a");
    hold(G, R, 0, 2, "yel.pre");
    hold(Y, R, 0, 5, "yel.short");
    hold(R, R, 0, 2, "yel.red");
    do_reset("reset5b");
    hold(G, R, 0, 2, "yel.pre2");
    hold(Y, R, 0, MINY, "yel.exact");
    hold(R, R, 0, 3, "yel.ok");

    // 6: clear handling
    do_reset("reset6");
    hold(G, R, 0, 2, "clr.pre");
    cyc(G, G, 0, "clr.fault");
    hold(G, G, 1, 3, "clr.conflict");
    cyc(3'b000, R, 1, "clr.invalid");
    cyc(G, R, 1, "clr.ok");
    cyc(G, R, 1, "clr.idle");
    legal_cycle("clr.legal");
    cyc(G, G, 0, "clr.refault");
    hold(G, R, 0, 5, "clr.faulted");
    do_reset("reset.midfault");

    // Randomized: controller-like phases with corruption and random clears
    phase = 0;
    cur_h = G;
    cur_f = R;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        // keep current drive
      end else if (r < 86) begin
        phase = (phase + 1) % 4;
        cur_h = ph_h[phase];
        cur_f = ph_f[phase];
      end else if (r < 93) begin
        cur_h = 3'($urandom_range(0, 7));
      end else begin
        cur_f = 3'($urandom_range(0, 7));
      end
      clr = ($urandom_range(0, 5) == 0);
      cyc(cur_h, cur_f, clr, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
